// File: rtl/adder_delay_meter.sv
// Ring-oscillator delay meter for a bank of adders: drives one adder's ring
// for a programmed window and counts its edges, or captures one static sum.
module adder_delay_meter #(
    parameter int WIDTH      = 32,
    parameter int NUM_ADDERS = 4,
    parameter int SEL_W      = 2,
    parameter int COUNT_W    = 24,
    parameter int WIN_W      = 16,
    parameter int SETTLE     = 2
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        start,
    input  logic                        mode,
    input  logic [SEL_W-1:0]            sel,
    input  logic [WIDTH-1:0]            a_in,
    input  logic [WIDTH-1:0]            b_in,
    input  logic [WIN_W-1:0]            window_cycles,
    input  logic [NUM_ADDERS-1:0]       ring_in,
    input  logic [NUM_ADDERS*WIDTH-1:0] sum_in,
    output logic [NUM_ADDERS-1:0]       ring_en,
    output logic [WIDTH-1:0]            adder_a,
    output logic [WIDTH-1:0]            adder_b,
    output logic                        busy,
    output logic                        done,
    output logic [COUNT_W-1:0]          count_out,
    output logic [WIDTH-1:0]            sum_out,
    output logic                        overflow,
    output logic                        sel_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_FLUSH   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]         state_q, state_d;
    logic               mode_q, mode_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [WIN_W-1:0]   tmr_q, tmr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               selerr_q, selerr_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [1:0]         sync_q;
    logic               prev_q;
    logic               ring_sel;
    logic [WIDTH-1:0]   sum_sel;
    logic               rise;

    always_comb begin
        ring_sel = 1'b0;
        sum_sel  = '0;
        for (int k = 0; k < NUM_ADDERS; k++) begin
            if (sel_q == SEL_W'(k)) begin
                ring_sel = ring_in[k];
                sum_sel  = sum_in[k*WIDTH +: WIDTH];
            end
        end
    end

    assign rise = sync_q[1] & ~prev_q;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        sel_d    = sel_q;
        a_d      = a_q;
        b_d      = b_q;
        win_d    = win_q;
        tmr_d    = tmr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        selerr_d = selerr_q;
        sum_d    = sum_q;
        // FLUSH keeps counting so edges still in the synchroniser land
        if (rise && (state_q == S_RUN || state_q == S_FLUSH)) begin
            if (&count_q) ovf_d = 1'b1;
            else count_d = count_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    sel_d   = sel;
                    a_d     = a_in;
                    b_d     = b_in;
                    win_d   = window_cycles;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    if (int'(sel) >= NUM_ADDERS) begin
                        selerr_d = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        selerr_d = 1'b0;
                        tmr_d    = WIN_W'(SETTLE - 1);
                        state_d  = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (tmr_q == '0) begin
                    if (mode_q) begin
                        state_d = S_CAPTURE;
                    end else if (win_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        tmr_d   = win_q - 1'b1;
                        state_d = S_RUN;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_CAPTURE: begin
                sum_d   = sum_sel;
                state_d = S_DONE;
            end
            S_RUN: begin
                if (tmr_q == '0) begin
                    tmr_d   = WIN_W'(2);
                    state_d = S_FLUSH;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_FLUSH: begin
                if (tmr_q == '0) state_d = S_DONE;
                else tmr_d = tmr_q - 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            sel_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            win_q    <= '0;
            tmr_q    <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            selerr_q <= 1'b0;
            sum_q    <= '0;
            sync_q   <= '0;
            prev_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            sel_q    <= sel_d;
            a_q      <= a_d;
            b_q      <= b_d;
            win_q    <= win_d;
            tmr_q    <= tmr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            selerr_q <= selerr_d;
            sum_q    <= sum_d;
            sync_q   <= {sync_q[0], ring_sel};
            prev_q   <= sync_q[1];
        end
    end

    always_comb begin
        ring_en = '0;
        if (state_q == S_RUN) begin
            for (int k = 0; k < NUM_ADDERS; k++) begin
                ring_en[k] = (sel_q == SEL_W'(k));
            end
        end
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign adder_a   = a_q;
    assign adder_b   = b_q;
    assign count_out = count_q;
    assign sum_out   = sum_q;
    assign overflow  = ovf_q;
    assign sel_err   = selerr_q;

endmodule

// File: tb/tb_adder_delay_meter.sv
// Directed bench for adder_delay_meter: main instance plus a 4-bit counter
// instance driven in parallel to exercise saturation.
`timescale 1ns/1ps
module tb_adder_delay_meter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 3;
    localparam int WW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start, mode;
    logic [SW-1:0] sel;
    logic [W-1:0]  a, b;
    logic [WW-1:0] win;

    logic [N-1:0]   ring_m, ring_s, en_m, en_s;
    logic [N*W-1:0] sum_m, sum_s;
    logic [W-1:0]   a_m, b_m, a_s, b_s, so_m, so_s, s_m, s_s;
    logic           busy_m, busy_s, done_m, done_s;
    logic           ovf_m, ovf_s, se_m, se_s;
    logic [23:0]    cnt_m;
    logic [3:0]     cnt_s;

    assign s_m   = a_m + b_m;
    assign s_s   = a_s + b_s;
    assign sum_m = {N{s_m}};
    assign sum_s = {N{s_s}};

    adder_delay_meter #(.SEL_W(SW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .mode(mode),
        .sel(sel), .a_in(a), .b_in(b), .window_cycles(win),
        .ring_in(ring_m), .sum_in(sum_m), .ring_en(en_m),
        .adder_a(a_m), .adder_b(b_m), .busy(busy_m), .done(done_m),
        .count_out(cnt_m), .sum_out(so_m), .overflow(ovf_m),
        .sel_err(se_m)
    );

    adder_delay_meter #(.SEL_W(SW), .COUNT_W(4)) dut_sat (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .mode(mode),
        .sel(sel), .a_in(a), .b_in(b), .window_cycles(win),
        .ring_in(ring_s), .sum_in(sum_s), .ring_en(en_s),
        .adder_a(a_s), .adder_b(b_s), .busy(busy_s), .done(done_s),
        .count_out(cnt_s), .sum_out(so_s), .overflow(ovf_s),
        .sel_err(se_s)
    );

    // Rings only oscillate while enabled: period 4 (main), period 2 (sat)
    int rc_m = 0;
    int rc_s = 0;
    always @(negedge clk) begin
        if (en_m[1]) rc_m <= rc_m + 1;
        else if (!busy_m) rc_m <= 0;
        if (en_s[1]) rc_s <= rc_s + 1;
        else if (!busy_s) rc_s <= 0;
    end
    assign ring_m = {2'b00, rc_m[1], 1'b0};
    assign ring_s = {2'b00, rc_s[0], 1'b0};

    int n_cmp = 0;
    int n_bad = 0;
    int lat, en_hits, en_other, dones;
    logic [N-1:0] exp_en;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // lat counts cycles from the start cycle to the done cycle
    task automatic wait_done(input int max);
        lat      = 1;
        en_hits  = 0;
        en_other = 0;
        while (!done_m && lat < max) begin
            if (en_m == exp_en && en_m != '0) en_hits++;
            else if (en_m != '0) en_other++;
            tick();
            lat++;
        end
        if (!done_m) chk("done_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; sel = '0;
        a = '0; b = '0; win = '0; exp_en = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", busy_m, 0);
        chk("rst_done", done_m, 0);
        chk("rst_en", en_m, 0);
        chk("rst_cnt", cnt_m, 0);
        chk("rst_sum", so_m, 0);
        chk("rst_a", a_m, 0);

        // ring measure, sel 1, 100-cycle window
        mode = 1'b0; sel = 3'd1; win = 16'd100; a = 32'd3; b = 32'd4;
        exp_en = 4'b0010;
        pulse_start();
        chk("ring_busy", busy_m, 1);
        wait_done(400);
        chk("ring_lat", lat, 106);
        chk("ring_en_cycles", en_hits, 100);
        chk("ring_en_other", en_other, 0);
        chk("ring_cnt", 32'((cnt_m >= 24) && (cnt_m <= 26)), 1);
        chk("ring_ovf", ovf_m, 0);
        chk("ring_busy_done", busy_m, 0);
        chk("sat_cnt", cnt_s, 15);
        chk("sat_ovf", ovf_s, 1);
        tick();
        chk("ring_done_width", done_m, 0);
        chk("ring_cnt_hold", 32'((cnt_m >= 24) && (cnt_m <= 26)), 1);

        // static sum capture on channel 0
        mode = 1'b1; sel = 3'd0; win = 16'd0; a = 32'd5; b = 32'd2;
        exp_en = 4'b0001;
        pulse_start();
        chk("static_a", a_m, 5);
        chk("static_b", b_m, 2);
        wait_done(50);
        chk("static_lat", lat, 4);
        chk("static_sum", so_m, 7);
        chk("static_cnt", cnt_m, 0);
        chk("static_en", en_hits + en_other, 0);
        tick();

        // zero window
        mode = 1'b0; sel = 3'd2; win = 16'd0; exp_en = 4'b0100;
        pulse_start();
        wait_done(50);
        chk("win0_lat", lat, 3);
        chk("win0_en", en_hits + en_other, 0);
        chk("win0_cnt", cnt_m, 0);
        chk("win0_sum_kept", so_m, 7);
        tick();

        // out-of-range channel
        sel = 3'd5; win = 16'd10;
        pulse_start();
        wait_done(20);
        chk("selerr_lat", lat, 1);
        chk("selerr_flag", se_m, 1);
        chk("selerr_cnt", cnt_m, 0);
        chk("selerr_sum_kept", so_m, 7);
        tick();

        // start held high: one run, DONE-cycle start ignored
        sel = 3'd3; win = 16'd10; exp_en = 4'b1000;
        start = 1'b1;
        tick();
        chk("hold_selerr_clr", se_m, 0);
        wait_done(100);
        chk("hold_lat", lat, 16);
        chk("hold_en_cycles", en_hits, 10);
        tick();
        chk("hold_idle_busy", busy_m, 0);
        chk("hold_idle_done", done_m, 0);
        tick();
        chk("hold_rerun_busy", busy_m, 1);
        start = 1'b0;
        wait_done(100);
        tick();

        // reset in the middle of a run
        sel = 3'd1; win = 16'd100; exp_en = 4'b0010;
        pulse_start();
        repeat (30) tick();
        chk("mid_busy", busy_m, 1);
        chk("mid_en", en_m, 4'b0010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_en", en_m, 0);
        chk("mid_rst_busy", busy_m, 0);
        chk("mid_rst_cnt", cnt_m, 0);
        dones = 0;
        for (int i = 0; i < 120; i++) begin
            if (done_m) dones++;
            tick();
        end
        chk("mid_rst_no_done", dones, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
